// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared size/exception codes, FSM encoding, alignment helper
package load_store_unit_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_ADEL = 2'd1;
  localparam logic [1:0] EXC_ADES = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // A dword access can never be aligned on a 32-bit bus.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size,
                                         input int dw);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_BYTE:  mis = 1'b0;
      SZ_HALF:  mis = addr_lo[0];
      SZ_WORD:  mis = |addr_lo[1:0];
      SZ_DWORD: mis = (dw == 32) || (|addr_lo);
      default:  mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and memory bus signals of the load/store unit
interface load_store_unit_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          flush;

  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW/8-1:0] mem_be;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;

  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_exc;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, flush,
    input  mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output rsp_valid, rsp_rdata, rsp_exc
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, flush,
    output mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  rsp_valid, rsp_rdata, rsp_exc
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// rtl/load_store_unit_load_align.sv - extracts the addressed bytes of a bus word and sign/zero-extends them
module load_align #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]           i_rdata,
  input  logic [$clog2(DW/8)-1:0] i_offset,
  input  logic [1:0]              i_size,
  input  logic                    i_signed,
  output logic [DW-1:0]           o_data
);
  logic [DW-1:0] w_shift;
  logic          w_fill;
  int            w_nbits;

  always_comb begin
    w_shift = i_rdata >> {i_offset, 3'b000};
    w_nbits = 8 << i_size;
    case (i_size)
      2'd0:    w_fill = i_signed & w_shift[7];
      2'd1:    w_fill = i_signed & w_shift[15];
      2'd2:    w_fill = i_signed & w_shift[31];
      default: w_fill = i_signed & w_shift[DW-1];
    endcase
    // A full-width access keeps every bit, so the fill never lands.
    o_data = '0;
    for (int i = 0; i < DW; i++) begin
      o_data[i] = (i < w_nbits) ? w_shift[i] : w_fill;
    end
  end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit: alignment check, lane steering, flush kill
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);
  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);

  lsu_state_e    r_state;
  lsu_state_e    w_next;
  logic          r_we;
  logic          r_signed;
  logic          r_kill;
  logic [1:0]    r_size;
  logic [1:0]    r_exc;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;

  logic          w_accept;
  logic          w_mis;
  logic [OW-1:0] w_off;
  logic [3:0]    w_nbytes;
  logic [NB-1:0] w_be;
  logic [DW-1:0] w_wmask;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_load;

  assign w_accept = bus.req_valid && (r_state == ST_IDLE);
  assign w_mis    = is_misaligned(bus.req_addr[2:0], bus.req_size, DW);
  assign w_off    = r_addr[OW-1:0];
  assign w_nbytes = 4'd1 << r_size;

  always_comb begin
    w_be    = '0;
    w_wmask = '0;
    for (int i = 0; i < NB; i++) begin
      w_be[i] = (i >= int'(w_off)) && (i < int'(w_off) + int'(w_nbytes));
      w_wmask[8*i +: 8] = (i < int'(w_nbytes)) ? 8'hFF : 8'h00;
    end
  end

  assign w_wdata = (r_wdata & w_wmask) << {w_off, 3'b000};

  load_align #(.DW(DW)) u_load_align (
    .i_rdata  (bus.mem_rdata),
    .i_offset (w_off),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_load)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_exc   = EXC_NONE;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (w_accept) w_next = w_mis ? ST_RESP : ST_BUS;
      end
      ST_BUS: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = r_we;
        bus.mem_addr  = {r_addr[AW-1:OW], {OW{1'b0}}};
        bus.mem_be    = w_be;
        bus.mem_wdata = r_we ? w_wdata : '0;
        if (bus.mem_ack) w_next = ST_RESP;
      end
      ST_RESP: begin
        if (!r_kill) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_rdata = r_rdata;
          bus.rsp_exc   = r_exc;
        end
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_kill   <= 1'b0;
      r_size   <= SZ_BYTE;
      r_exc    <= EXC_NONE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else if (w_accept) begin
      r_we     <= bus.req_we;
      r_signed <= bus.req_signed;
      r_kill   <= bus.flush;
      r_size   <= bus.req_size;
      r_addr   <= bus.req_addr;
      r_wdata  <= bus.req_wdata;
      r_rdata  <= '0;
      r_exc    <= !w_mis ? EXC_NONE : (bus.req_we ? EXC_ADES : EXC_ADEL);
    end else if (r_state == ST_BUS) begin
      // The access still runs to ack after a flush; only the response is suppressed.
      if (bus.flush) r_kill <= 1'b1;
      if (bus.mem_ack && !r_we) r_rdata <= w_load;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit at DW=32 and DW=64
module tb_load_store_unit;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  load_store_unit_if #(.DW(32), .AW(32)) b32 ();
  load_store_unit_if #(.DW(64), .AW(32)) b64 ();

  load_store_unit #(.DW(32), .AW(32)) dut32 (.clk(clk), .reset(rst_n), .bus(b32.slave));
  load_store_unit #(.DW(64), .AW(32)) dut64 (.clk(clk), .reset(rst_n), .bus(b64.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc32(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input logic [31:0] exp_maddr, input logic [3:0] exp_be,
                       input logic [31:0] exp_mwdata, input logic [31:0] exp_rdata,
                       input logic [1:0] exp_exc);
    b32.req_valid = 1'b1; b32.req_we = we; b32.req_size = size; b32.req_signed = sgn;
    b32.req_addr = addr; b32.req_wdata = wdata;
    chk({tag, "_ready"}, 64'(b32.req_ready), 64'd1);
    step();
    b32.req_valid = 1'b0;
    if (exp_exc != 2'd0) begin
      chk({tag, "_nomemreq"}, 64'(b32.mem_req), 64'd0);
      chk({tag, "_rspv"}, 64'(b32.rsp_valid), 64'd1);
      chk({tag, "_exc"}, 64'(b32.rsp_exc), 64'(exp_exc));
    end else begin
      chk({tag, "_memreq"}, 64'(b32.mem_req), 64'd1);
      chk({tag, "_memwe"}, 64'(b32.mem_we), 64'(we));
      chk({tag, "_maddr"}, 64'(b32.mem_addr), 64'(exp_maddr));
      chk({tag, "_be"}, 64'(b32.mem_be), 64'(exp_be));
      chk({tag, "_mwdata"}, 64'(b32.mem_wdata), 64'(exp_mwdata));
      chk({tag, "_early"}, 64'(b32.rsp_valid), 64'd0);
      b32.mem_ack = 1'b1; b32.mem_rdata = rdata;
      step();
      b32.mem_ack = 1'b0; b32.mem_rdata = '0;
      chk({tag, "_rspv"}, 64'(b32.rsp_valid), 64'd1);
      chk({tag, "_rdata"}, 64'(b32.rsp_rdata), 64'(exp_rdata));
      chk({tag, "_exc"}, 64'(b32.rsp_exc), 64'd0);
      chk({tag, "_busy"}, 64'(b32.req_ready), 64'd0);
    end
    step();
    chk({tag, "_idle"}, 64'(b32.req_ready), 64'd1);
    chk({tag, "_rspdone"}, 64'(b32.rsp_valid), 64'd0);
  endtask

  task automatic acc64(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                       input logic [31:0] exp_maddr, input logic [7:0] exp_be,
                       input logic [63:0] exp_mwdata, input logic [63:0] exp_rdata);
    b64.req_valid = 1'b1; b64.req_we = we; b64.req_size = size; b64.req_signed = sgn;
    b64.req_addr = addr; b64.req_wdata = wdata;
    step();
    b64.req_valid = 1'b0;
    chk({tag, "_memreq"}, 64'(b64.mem_req), 64'd1);
    chk({tag, "_maddr"}, 64'(b64.mem_addr), 64'(exp_maddr));
    chk({tag, "_be"}, 64'(b64.mem_be), 64'(exp_be));
    chk({tag, "_mwdata"}, b64.mem_wdata, exp_mwdata);
    b64.mem_ack = 1'b1; b64.mem_rdata = rdata;
    step();
    b64.mem_ack = 1'b0; b64.mem_rdata = '0;
    chk({tag, "_rspv"}, 64'(b64.rsp_valid), 64'd1);
    chk({tag, "_rdata"}, b64.rsp_rdata, exp_rdata);
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    b32.req_valid = 0; b32.req_we = 0; b32.req_size = 0; b32.req_signed = 0;
    b32.req_addr = '0; b32.req_wdata = '0; b32.flush = 0; b32.mem_ack = 0; b32.mem_rdata = '0;
    b64.req_valid = 0; b64.req_we = 0; b64.req_size = 0; b64.req_signed = 0;
    b64.req_addr = '0; b64.req_wdata = '0; b64.flush = 0; b64.mem_ack = 0; b64.mem_rdata = '0;
    step();
    chk("rst_ready", 64'(b32.req_ready), 64'd1);
    chk("rst_memreq", 64'(b32.mem_req), 64'd0);
    chk("rst_be", 64'(b32.mem_be), 64'd0);
    chk("rst_rspv", 64'(b32.rsp_valid), 64'd0);
    chk("rst64_ready", 64'(b64.req_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();

    acc32("lb_1003", 0, 2'd0, 1, 32'h1003, 32'h0, 32'h80AABBCC, 32'h1000, 4'b1000, 32'h0, 32'hFFFFFF80, 2'd0);
    acc32("lhu_2002", 0, 2'd1, 0, 32'h2002, 32'h0, 32'h9ABC1234, 32'h2000, 4'b1100, 32'h0, 32'h00009ABC, 2'd0);
    acc32("lh_2002", 0, 2'd1, 1, 32'h2002, 32'h0, 32'h9ABC1234, 32'h2000, 4'b1100, 32'h0, 32'hFFFF9ABC, 2'd0);
    acc32("lbu_1001", 0, 2'd0, 0, 32'h1001, 32'h0, 32'h80AABBCC, 32'h1000, 4'b0010, 32'h0, 32'h000000BB, 2'd0);
    acc32("lw_3000", 0, 2'd2, 1, 32'h3000, 32'h0, 32'h87654321, 32'h3000, 4'b1111, 32'h0, 32'h87654321, 2'd0);
    acc32("sh_0006", 1, 2'd1, 0, 32'h0006, 32'h0000BEEF, 32'hFFFFFFFF, 32'h0004, 4'b1100, 32'hBEEF0000, 32'h0, 2'd0);
    acc32("sb_0001", 1, 2'd0, 0, 32'h0001, 32'hFFFFFF5A, 32'hFFFFFFFF, 32'h0000, 4'b0010, 32'h00005A00, 32'h0, 2'd0);
    acc32("sw_0005", 1, 2'd2, 0, 32'h0005, 32'h12345678, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 2'd2);
    acc32("lh_0003", 0, 2'd1, 1, 32'h0003, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 2'd1);
    acc32("ld32_0008", 0, 2'd3, 0, 32'h0008, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0, 2'd1);

    acc64("ld64_0008", 0, 2'd3, 0, 32'h8, 64'h0, 64'h0123456789ABCDEF, 32'h8, 8'hFF, 64'h0, 64'h0123456789ABCDEF);
    acc64("lw64_000c", 0, 2'd2, 1, 32'hC, 64'h0, 64'h8000000011111111, 32'h8, 8'hF0, 64'h0, 64'hFFFFFFFF80000000);
    acc64("sh64_000a", 1, 2'd1, 0, 32'hA, 64'h1234, 64'h0, 32'h8, 8'h0C, 64'h12340000, 64'h0);

    // Stray ack and flush while idle must leave the next access untouched.
    b32.mem_ack = 1'b1; b32.flush = 1'b1;
    step();
    b32.mem_ack = 1'b0; b32.flush = 1'b0;
    chk("idle_ack_ready", 64'(b32.req_ready), 64'd1);
    chk("idle_ack_rspv", 64'(b32.rsp_valid), 64'd0);
    acc32("lw_after_idle", 0, 2'd2, 0, 32'h10, 32'h0, 32'hCAFEF00D, 32'h10, 4'b1111, 32'h0, 32'hCAFEF00D, 2'd0);

    // Delayed ack with flush in the second bus cycle.
    b32.req_valid = 1; b32.req_we = 1; b32.req_size = 2'd2; b32.req_addr = 32'h40; b32.req_wdata = 32'hA5A5A5A5;
    step();
    b32.req_valid = 0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("fl_memreq%0d", c), 64'(b32.mem_req), 64'd1);
      chk($sformatf("fl_maddr%0d", c), 64'(b32.mem_addr), 64'h40);
      chk($sformatf("fl_wdata%0d", c), 64'(b32.mem_wdata), 64'hA5A5A5A5);
      chk($sformatf("fl_rspv%0d", c), 64'(b32.rsp_valid), 64'd0);
      b32.flush   = (c == 1);
      b32.mem_ack = (c == 2);
      step();
    end
    b32.flush = 0; b32.mem_ack = 0;
    chk("fl_resp_rspv", 64'(b32.rsp_valid), 64'd0);
    chk("fl_resp_ready", 64'(b32.req_ready), 64'd0);
    step();
    chk("fl_back_ready", 64'(b32.req_ready), 64'd1);

    // Flush in the acceptance cycle also kills the response.
    b32.req_valid = 1; b32.req_we = 0; b32.req_size = 2'd0; b32.req_addr = 32'h7; b32.flush = 1;
    step();
    b32.req_valid = 0; b32.flush = 0;
    chk("fa_memreq", 64'(b32.mem_req), 64'd1);
    b32.mem_ack = 1; b32.mem_rdata = 32'h11223344;
    step();
    b32.mem_ack = 0;
    chk("fa_rspv", 64'(b32.rsp_valid), 64'd0);
    step();

    // Flush during RESP has no effect on the response already presented.
    b32.req_valid = 1; b32.req_we = 0; b32.req_size = 2'd0; b32.req_signed = 0; b32.req_addr = 32'h4;
    step();
    b32.req_valid = 0; b32.mem_ack = 1; b32.mem_rdata = 32'h000000EE;
    step();
    b32.mem_ack = 0; b32.flush = 1;
    #1;
    chk("fr_rspv", 64'(b32.rsp_valid), 64'd1);
    chk("fr_rdata", 64'(b32.rsp_rdata), 64'hEE);
    step();
    b32.flush = 0;

    // Reset during BUS abandons the access; a later ack is ignored.
    b32.req_valid = 1; b32.req_we = 1; b32.req_size = 2'd2; b32.req_addr = 32'h50; b32.req_wdata = 32'hDEADBEEF;
    step();
    b32.req_valid = 0;
    chk("rb_memreq", 64'(b32.mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rb_async_memreq", 64'(b32.mem_req), 64'd0);
    chk("rb_async_ready", 64'(b32.req_ready), 64'd1);
    chk("rb_async_wdata", 64'(b32.mem_wdata), 64'd0);
    step();
    rst_n = 1'b1; b32.mem_ack = 1'b1;
    step();
    b32.mem_ack = 1'b0;
    chk("rb_rspv", 64'(b32.rsp_valid), 64'd0);
    chk("rb_memreq_after", 64'(b32.mem_req), 64'd0);
    chk("rb_ready_after", 64'(b32.req_ready), 64'd1);
    chk("rb_exc_after", 64'(b32.rsp_exc), 64'd0);
    step();
    chk("rb_rspv2", 64'(b32.rsp_valid), 64'd0);
    acc32("lw_after_rst", 0, 2'd2, 0, 32'h60, 32'h0, 32'h0BADF00D, 32'h60, 4'b1111, 32'h0, 32'h0BADF00D, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL have parameter DW, default 32, data/bus width in bits; only 32 and 64 are legal.
REQ-002 The module SHALL have parameter AW, default 32, byte-address width.
REQ-003 The module SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 The module SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port req_valid  in  1  core request valid.
REQ-006 The module SHALL have port req_ready  out  1  unit can accept a request.
REQ-007 The module SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-008 The module SHALL have port req_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-009 The module SHALL have port req_signed  in  1  sign-extend the load result (1) or zero-extend it (0).
REQ-010 The module SHALL have port req_addr  in  AW  byte address.
REQ-011 The module SHALL have port req_wdata  in  DW  store data, right-aligned.
REQ-012 The module SHALL have port flush  in  1  cancel the response of the in-flight access.
REQ-013 The module SHALL have ports mem_req/mem_we  out  1 each, plus mem_addr  out  AW (lane-aligned), mem_be  out  DW/8, mem_wdata  out  DW.
REQ-014 The module SHALL have ports mem_ack  in  1 and mem_rdata  in  DW  (read data, valid with mem_ack).
REQ-015 The module SHALL have ports rsp_valid  out  1, rsp_rdata  out  DW, rsp_exc  out  2  (0 none, 1 AdEL, 2 AdES).

Function
REQ-016 The FSM SHALL have the states IDLE, BUS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 On req_valid&&req_ready the unit SHALL latch we, size, signed, addr and wdata.
REQ-018 A request SHALL count as misaligned when addr mod 2^size != 0, or when size==3 with DW==32.
REQ-019 A misaligned request SHALL go IDLE->RESP with no bus access, and rsp_exc SHALL be AdES for a store, AdEL for a load.
REQ-020 An aligned request SHALL go IDLE->BUS and hold mem_req=1 with stable mem_* outputs until the cycle mem_ack=1, then go to RESP.
REQ-021 mem_addr SHALL equal addr with the low log2(DW/8) bits cleared.
REQ-022 lane offset SHALL be addr[log2(DW/8)-1:0]; mem_be SHALL have 2^size contiguous ones starting at bit offset.
REQ-023 A store SHALL place wdata's low 2^size bytes at byte lanes offset.. in mem_wdata; the other lanes SHALL be 0.
REQ-024 A load SHALL capture mem_rdata on the ack cycle, extract 2^size bytes at lane offset, and sign- or zero-extend them to DW per signed.
REQ-025 When size equals full width, extension SHALL NOT apply.
REQ-026 A store response SHALL return rsp_rdata=0.
REQ-027 RESP SHALL last exactly one cycle, with rsp_valid=1 unless killed, then return to IDLE.
REQ-028 Latency: with mem_ack in the first BUS cycle, rsp_valid SHALL assert 2 cycles after acceptance; a misaligned request SHALL give rsp_valid 1 cycle after acceptance.
REQ-029 flush in BUS, or in the acceptance cycle, SHALL set a kill flag, the bus access SHALL still complete to ack, and rsp_valid SHALL stay 0 in RESP.
REQ-030 flush in IDLE without acceptance, or in RESP, SHALL have no effect.
REQ-031 mem_ack outside BUS SHALL be ignored.

Reset
REQ-032 Asserting reset SHALL immediately force IDLE, clear the kill flag, and drive req_ready=1, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_exc=0.
REQ-033 Reset asserted during BUS SHALL abandon the access with no response, and a later mem_ack SHALL be ignored.

Structure
REQ-034 A shared package SHALL hold the size codes, exception codes and FSM state encoding.
REQ-035 Combinational lane extraction/extension SHALL live in one sub-module, load_align, parametrised by DW.

Verification
REQ-036 DW=32, lb signed at addr 0x1003, rdata 0x80AABBCC, ack in first BUS cycle -> rsp_rdata 0xFFFFFF80, rsp_valid at cycle +2.
REQ-037 DW=32, lhu at 0x2002, rdata 0x9ABC1234 -> rsp_rdata 0x00009ABC; lh -> 0xFFFF9ABC.
REQ-038 DW=32, sh at 0x0006, wdata 0x0000BEEF -> mem_addr 0x4, mem_be 4'b1100, mem_wdata 0xBEEF0000; sw at 0x0005 -> no mem_req, rsp_exc=2 next cycle.
REQ-039 DW=64, ld at 0x8, rdata 0x0123456789ABCDEF -> rsp unchanged; ld with DW=32 -> rsp_exc=1.
REQ-040 mem_ack delayed 3 cycles plus flush in 2nd BUS cycle -> mem_req held 3 cycles, stable mem_*, no rsp_valid, req_ready back after RESP.
REQ-041 reset pulsed during BUS, stray mem_ack afterwards -> all outputs at reset values, no rsp_valid.
